pwrbtn_press_classifier: RTL
============================

// Module: pwrbtn_press_classifier
// PURPOSE
//  Receive end of the CPLD button-press pulse interface. Samples an active-low, asynchronous
//  button/press line, synchronizes and debounces it on the 1 ms tick, and measures how long it
//  stays low. Each press is classified as a SHORT or LONG event and queued in a one-deep event
//  register, which the power-sequencing logic consumes through a valid/ack handshake.
// PARAMETERS
//  SYNC_STAGES   2     synchronizer flops on btn_n (minimum 2)
//  DEBOUNCE_MS   20    number of consecutive ms ticks btn_n must be stable before the clean level changes
//  SHORT_MIN_MS  30    minimum debounced low time for a SHORT event; shorter presses are discarded
//  LONG_MS       4000  debounced low time at which a LONG event is posted
//  CNT_W         13    width of the ms counters and press_ms; must hold LONG_MS
// PORTS
//  clock        in   1      system clock
//  reset        in   1      asynchronous, active-high reset
//  int_1ms_en   in   1      one-clock enable pulse, once per ms
//  btn_n        in   1      raw press line, asynchronous, 0 = pressed
//  evt_ack      in   1      consumer acknowledge; pops the pending event
//  btn_level    out  1      debounced level, 1 = released
//  long_hold    out  1      1 while the press is held at or beyond LONG_MS
//  evt_valid    out  1      an event is pending
//  evt_long     out  1      type of the pending event: 0 = SHORT, 1 = LONG
//  press_ms     out  CNT_W  ms count captured with the pending event (LONG: LONG_MS)
//  evt_overrun  out  1      one-clock pulse: an event was dropped because one was already pending
// BEHAVIOUR
//  Reset values: btn_level=1, long_hold=0, evt_valid=0, evt_long=0, press_ms=0, evt_overrun=0,
//   all synchronizer flops=1, FSM in IDLE. An async reset in mid-press discards that press;
//   after reset, an already-low line is debounced again like a new press.
//  Sync: btn_n passes through SYNC_STAGES flops, so there is SYNC_STAGES clocks of latency.
//  Debounce: any change of the synchronized value clears db_cnt. On each int_1ms_en, db_cnt
//   increments while sync != btn_level. When db_cnt reaches DEBOUNCE_MS, btn_level <= sync and
//   db_cnt clears. A change and a tick in the same clock count as a change.
//  Clean edges: fall = btn_level 1->0, rise = btn_level 0->1. Each is a single-clock strobe.
//  FSM (press_cnt saturates at LONG_MS and only counts on ticks while in PRESSED):
//   IDLE:    fall -> PRESSED, and press_cnt is cleared.
//   PRESSED: on each tick press_cnt++. When press_cnt reaches LONG_MS: post LONG, set
//            long_hold=1, -> LONG_HELD.
//            rise -> post SHORT if press_cnt >= SHORT_MIN_MS, else post nothing; -> IDLE.
//            If the rise and the reaching of LONG_MS fall in the same clock, LONG wins and
//            the FSM goes to IDLE.
//   LONG_HELD: rise -> long_hold=0, -> IDLE. No second event is posted.
//  Event register: a post loads evt_long/press_ms and sets evt_valid on the next clock.
//   evt_ack with evt_valid=1 clears evt_valid. evt_ack while evt_valid=0 is ignored.
//   A post while evt_valid=1 and no ack in that clock: the register keeps the old event and
//   evt_overrun pulses. A post and an ack in the same clock: the new event is loaded and
//   evt_valid stays 1.
//  Total latency from raw edge to evt_valid for SHORT: SYNC_STAGES + DEBOUNCE_MS ms + 2 clocks.
// STRUCTURE
//  Shared package/include: FSM state encodings (IDLE=2'b00, PRESSED=2'b01,
//   LONG_HELD=2'b10) and the EVT_SHORT/EVT_LONG constants.
//  One sub-module, btn_sync_debounce: synchronizer plus debounce counter, output btn_level.
//   The classifier FSM, press counter and event register live in the top module.
// TESTING (sim: DEBOUNCE_MS=20, SHORT_MIN_MS=30, LONG_MS=100, tick every 10 clocks)
//  1. btn_n low 60 ms then high -> one event, evt_long=0, press_ms=60 (+/-1);
//     btn_level follows each edge about 20 ms late.
//  2. btn_n toggling every 5 ms for 200 ms -> btn_level stays 1, no event, FSM stays IDLE.
//  3. btn_n low 25 ms (debounced low 25) -> no event, FSM back in IDLE, evt_overrun=0.
//  4. btn_n low 150 ms -> at 100 ms after the debounced fall: LONG event, press_ms=100,
//     long_hold=1; release -> long_hold=0 and no second event.
//  5. Two 60 ms presses with no ack -> first event kept, evt_overrun pulses once;
//     ack in the same clock as the second post -> second event loaded, evt_valid stays 1.
//  6. reset asserted 50 ms into a press -> all outputs at reset values; line still low
//     after reset -> new press measured from the new debounced fall.

Source files
------------

// File: rtl/pwrbtn_press_classifier_pkg.sv
// Shared encodings for the power-button press classifier: FSM states and event types.
package pwrbtn_press_classifier_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        PRESSED   = 2'b01,
        LONG_HELD = 2'b10
    } press_state_e;

    localparam logic EVT_SHORT = 1'b0;
    localparam logic EVT_LONG  = 1'b1;

endpackage

// File: rtl/pwrbtn_press_classifier_btn_sync_debounce.sv
// Synchronizes the raw active-low press line and debounces it on the 1 ms tick.
module btn_sync_debounce #(
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE_MS = 20,
    parameter int CNT_W       = 13
) (
    input  logic clock,
    input  logic reset,
    input  logic int_1ms_en,
    input  logic btn_n,
    output logic btn_level
);

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_MS - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   sync_prev_q, sync_prev_d;
    logic [CNT_W-1:0]       db_cnt_q, db_cnt_d;
    logic                   level_q, level_d;
    logic                   sync_val;

    assign sync_val  = sync_q[SYNC_STAGES-1];
    assign btn_level = level_q;

    always_comb begin
        sync_d      = {sync_q[SYNC_STAGES-2:0], btn_n};
        sync_prev_d = sync_val;
        level_d     = level_q;
        db_cnt_d    = db_cnt_q;
        // Any movement of the synchronized line restarts the stability window,
        // even if it coincides with a tick.
        if (sync_val != sync_prev_q) begin
            db_cnt_d = '0;
        end else if (sync_val == level_q) begin
            db_cnt_d = '0;
        end else if (int_1ms_en) begin
            if (db_cnt_q == DB_LAST) begin
                level_d  = sync_val;
                db_cnt_d = '0;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q      <= '1;
            sync_prev_q <= 1'b1;
            db_cnt_q    <= '0;
            level_q     <= 1'b1;
        end else begin
            sync_q      <= sync_d;
            sync_prev_q <= sync_prev_d;
            db_cnt_q    <= db_cnt_d;
            level_q     <= level_d;
        end
    end

endmodule

// File: rtl/pwrbtn_press_classifier.sv
// Classifies debounced button presses as SHORT or LONG and holds one pending event
// for the power-sequencing logic behind a valid/ack handshake.
module pwrbtn_press_classifier
    import pwrbtn_press_classifier_pkg::*;
#(
    parameter int SYNC_STAGES  = 2,
    parameter int DEBOUNCE_MS  = 20,
    parameter int SHORT_MIN_MS = 30,
    parameter int LONG_MS      = 4000,
    parameter int CNT_W        = 13
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             int_1ms_en,
    input  logic             btn_n,
    input  logic             evt_ack,
    output logic             btn_level,
    output logic             long_hold,
    output logic             evt_valid,
    output logic             evt_long,
    output logic [CNT_W-1:0] press_ms,
    output logic             evt_overrun
);

    localparam logic [CNT_W-1:0] LONG_C  = CNT_W'(LONG_MS);
    localparam logic [CNT_W-1:0] SHORT_C = CNT_W'(SHORT_MIN_MS);

    btn_sync_debounce #(
        .SYNC_STAGES (SYNC_STAGES),
        .DEBOUNCE_MS (DEBOUNCE_MS),
        .CNT_W       (CNT_W)
    ) u_sync_db (
        .clock      (clock),
        .reset      (reset),
        .int_1ms_en (int_1ms_en),
        .btn_n      (btn_n),
        .btn_level  (btn_level)
    );

    press_state_e     state_q, state_d;
    logic [CNT_W-1:0] press_cnt_q, press_cnt_d;
    logic             level_prev_q;
    logic             long_hold_q, long_hold_d;
    logic             evt_valid_q, evt_valid_d;
    logic             evt_long_q, evt_long_d;
    logic [CNT_W-1:0] press_ms_q, press_ms_d;
    logic             evt_overrun_q, evt_overrun_d;

    logic             fall, rise, reach;
    logic             post, post_long;
    logic [CNT_W-1:0] post_ms;

    assign fall = level_prev_q & ~btn_level;
    assign rise = ~level_prev_q & btn_level;

    assign long_hold   = long_hold_q;
    assign evt_valid   = evt_valid_q;
    assign evt_long    = evt_long_q;
    assign press_ms    = press_ms_q;
    assign evt_overrun = evt_overrun_q;

    always_comb begin
        state_d     = state_q;
        press_cnt_d = press_cnt_q;
        long_hold_d = long_hold_q;
        reach       = 1'b0;
        post        = 1'b0;
        post_long   = EVT_SHORT;
        post_ms     = '0;
        case (state_q)
            IDLE: begin
                if (fall) begin
                    state_d     = PRESSED;
                    press_cnt_d = '0;
                end
            end
            PRESSED: begin
                if (int_1ms_en && press_cnt_q < LONG_C) begin
                    press_cnt_d = press_cnt_q + 1'b1;
                    reach       = (press_cnt_q == LONG_C - 1'b1);
                end
                // Reaching LONG_MS takes priority over a release in the same clock.
                if (reach) begin
                    post      = 1'b1;
                    post_long = EVT_LONG;
                    post_ms   = LONG_C;
                    if (rise) begin
                        state_d = IDLE;
                    end else begin
                        long_hold_d = 1'b1;
                        state_d     = LONG_HELD;
                    end
                end else if (rise) begin
                    post    = (press_cnt_d >= SHORT_C);
                    post_ms = press_cnt_d;
                    state_d = IDLE;
                end
            end
            LONG_HELD: begin
                if (rise) begin
                    long_hold_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                long_hold_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    always_comb begin
        evt_valid_d   = evt_valid_q;
        evt_long_d    = evt_long_q;
        press_ms_d    = press_ms_q;
        evt_overrun_d = 1'b0;
        // A same-clock ack frees the slot, so the new event replaces the old one.
        if (post && (!evt_valid_q || evt_ack)) begin
            evt_valid_d = 1'b1;
            evt_long_d  = post_long;
            press_ms_d  = post_ms;
        end else if (post) begin
            evt_overrun_d = 1'b1;
        end else if (evt_ack) begin
            evt_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            press_cnt_q   <= '0;
            level_prev_q  <= 1'b1;
            long_hold_q   <= 1'b0;
            evt_valid_q   <= 1'b0;
            evt_long_q    <= EVT_SHORT;
            press_ms_q    <= '0;
            evt_overrun_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            press_cnt_q   <= press_cnt_d;
            level_prev_q  <= btn_level;
            long_hold_q   <= long_hold_d;
            evt_valid_q   <= evt_valid_d;
            evt_long_q    <= evt_long_d;
            press_ms_q    <= press_ms_d;
            evt_overrun_q <= evt_overrun_d;
        end
    end

endmodule
